// File: rtl/msg_framer_if.sv
// Signal bundle between message producers, msg_framer and the 64-bit stream link.
// Valid/ready: a beat moves on the rising clk edge where valid && ready are both 1; the
// sender holds valid and its payload stable until that edge and never drops valid early.
interface msg_framer_if #(
   parameter int MAX_MSG_BYTES = 32
);
   logic                       in_valid;
   logic                       in_ready;
   logic [15:0]                in_count;
   logic [15:0]                in_length;
   logic [8*MAX_MSG_BYTES-1:0] in_data;
   logic                       in_error;
   logic                       m_tvalid;
   logic                       m_tready;
   logic [63:0]                m_tdata;
   logic [7:0]                 m_tkeep;
   logic                       m_tlast;

   modport slave (
      input  in_valid, in_count, in_length, in_data, m_tready,
      output in_ready, in_error, m_tvalid, m_tdata, m_tkeep, m_tlast
   );

   modport master (
      output in_valid, in_count, in_length, in_data, m_tready,
      input  in_ready, in_error, m_tvalid, m_tdata, m_tkeep, m_tlast
   );
endinterface

// File: rtl/msg_framer.sv
// Packs length-prefixed messages into a count-headed, little-endian 64-bit AXI-Stream frame.
// Holds one message plus a sub-word residue; dbg_state exposes the FSM.
module msg_framer #(
   parameter int MAX_MSG_BYTES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   msg_framer_if.slave bus,
   output logic [1:0]  dbg_state
);
   localparam int ACC_W = 8 * (MAX_MSG_BYTES + 9);
   localparam int V_W   = 8 * (MAX_MSG_BYTES + 2);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCEPT = 2'd1;
   localparam logic [1:0] EMIT   = 2'd2;

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       acc_cnt;
   logic [15:0]      msg_rem;
   logic             frame_open;
   logic             finishing;
   logic             in_error_q;

   logic             accept;
   logic             xfer;
   logic [15:0]      len_eff;
   logic [15:0]      cnt_eff;
   logic [V_W-1:0]   vec;
   logic [ACC_W-1:0] first_acc;
   logic [ACC_W-1:0] next_acc;
   logic             tvalid;
   logic             tlast;
   logic [7:0]       tkeep;
   logic [63:0]      tdata;

   // Message vector: clamped length field, then payload with bytes past L forced to zero.
   always_comb begin
      len_eff = (bus.in_length > 16'(MAX_MSG_BYTES)) ? 16'(MAX_MSG_BYTES) : bus.in_length;
      cnt_eff = (bus.in_count == 16'd0) ? 16'd1 : bus.in_count;
      vec = '0;
      vec[15:0] = len_eff;
      for (int i = 0; i < MAX_MSG_BYTES; i++) begin
         if (16'(i) < len_eff) vec[16+8*i +: 8] = bus.in_data[8*i +: 8];
      end
      first_acc = '0;
      first_acc[V_W+15:0] = {vec, cnt_eff};
      next_acc = acc | ({{(ACC_W-V_W){1'b0}}, vec} << {acc_cnt, 3'b000});
   end

   always_comb begin
      tvalid = (state == EMIT) && ((acc_cnt >= 8'd8) || (finishing && acc_cnt != 8'd0));
      tlast  = tvalid && finishing && (acc_cnt <= 8'd8);
      tkeep  = '0;
      tdata  = '0;
      if (tvalid) begin
         tkeep = (acc_cnt >= 8'd8) ? 8'hFF : ((8'd1 << acc_cnt[2:0]) - 8'd1);
         for (int k = 0; k < 8; k++) begin
            if (8'(k) < acc_cnt) tdata[8*k +: 8] = acc[8*k +: 8];
         end
      end
   end

   assign accept       = bus.in_valid && (state == ACCEPT);
   assign xfer         = tvalid && bus.m_tready;
   assign bus.in_ready = (state == ACCEPT);
   assign bus.in_error = in_error_q;
   assign bus.m_tvalid = tvalid;
   assign bus.m_tlast  = tlast;
   assign bus.m_tkeep  = tkeep;
   assign bus.m_tdata  = tdata;
   assign dbg_state    = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         acc        <= '0;
         acc_cnt    <= '0;
         msg_rem    <= '0;
         frame_open <= 1'b0;
         finishing  <= 1'b0;
         in_error_q <= 1'b0;
      end else begin
         in_error_q <= accept && ((bus.in_length > 16'(MAX_MSG_BYTES)) ||
                                  (!frame_open && bus.in_count == 16'd0));
         case (state)
            IDLE: state <= ACCEPT;
            ACCEPT: begin
               if (accept) begin
                  state <= EMIT;
                  if (!frame_open) begin
                     acc        <= first_acc;
                     acc_cnt    <= 8'd4 + 8'(len_eff);
                     msg_rem    <= cnt_eff - 16'd1;
                     frame_open <= 1'b1;
                     finishing  <= (cnt_eff == 16'd1);
                  end else begin
                     acc       <= next_acc;
                     acc_cnt   <= acc_cnt + 8'd2 + 8'(len_eff);
                     msg_rem   <= msg_rem - 16'd1;
                     finishing <= (msg_rem == 16'd1);
                  end
               end
            end
            EMIT: begin
               if (xfer && tlast) begin
                  acc        <= '0;
                  acc_cnt    <= '0;
                  finishing  <= 1'b0;
                  frame_open <= 1'b0;
                  state      <= ACCEPT;
               end else if (xfer) begin
                  // A non-final word always carries a full 8 bytes.
                  acc     <= acc >> 64;
                  acc_cnt <= acc_cnt - 8'd8;
                  if (acc_cnt < 8'd16 && !finishing) state <= ACCEPT;
               end else if (!tvalid) begin
                  state <= ACCEPT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/msg_framer.md
# msg_framer

Transmit-side counterpart of `msg_parser`. Accepts one message per handshake (length plus up to `MAX_MSG_BYTES` payload bytes) and packs the messages into a 64-bit AXI-Stream frame in exactly the format `msg_parser` consumes. The frame format is a 2-byte message count, then per message a 2-byte length and its payload, contiguous and little-endian, with `tlast` on the final word. It sits between message producers and the stream link, and buffers only one message plus a sub-word residue.

## Interface
Parameters:
- `MAX_MSG_BYTES`, default 32. Maximum payload bytes per message. Legal range 8..64.

Ports:
- `clk`, input, 1 bit. Single clock; all logic on the rising edge.
- `rst_n`, input, 1 bit. Asynchronous, active-low reset.
- `in_valid`, input, 1 bit. Message presented.
- `in_ready`, output, 1 bit. Block can accept a message this cycle.
- `in_count`, input, 16 bits. Number of messages in the frame. Sampled only on the first message of a frame.
- `in_length`, input, 16 bits. Payload byte count of this message.
- `in_data`, input, `8*MAX_MSG_BYTES` bits. Payload; byte 0 is on `[7:0]`.
- `in_error`, output, 1 bit. One-cycle pulse: the accepted message had `in_length > MAX_MSG_BYTES`, or the first message of a frame had `in_count == 0`.
- `m_tvalid`, output, 1 bit. AXI-Stream output, valid.
- `m_tready`, input, 1 bit. AXI-Stream output, ready.
- `m_tdata`, output, 64 bits. AXI-Stream output data. Byte k of a word is on `[8k+7:8k]`.
- `m_tkeep`, output, 8 bits. AXI-Stream output byte enables.
- `m_tlast`, output, 1 bit. AXI-Stream output, last word of the frame.

## Operation
- Byte accumulator `acc`: `MAX_MSG_BYTES+9` bytes wide, with a fill count `acc_cnt`. Bytes are packed from byte 0 upward.
- States and transitions:
  - IDLE (reset state) moves to ACCEPT on the next cycle.
  - In ACCEPT, `in_ready` is 1. An accept (`in_valid && in_ready`) moves the block to EMIT.
  - In EMIT, `in_ready` is 0.
  - EMIT moves back to ACCEPT when `acc_cnt < 8` and the frame is not finishing, or when the final word of a frame is transferred.
- Length clamp:
  - Effective length is `L = min(in_length, MAX_MSG_BYTES)`.
  - The emitted length field equals `L`.
  - `in_data` bytes at index ≥ L are ignored and emitted as zeros.
- Message vector: `V` = {payload bytes 0..L-1, `L[15:8]`, `L[7:0]`}, with `L[7:0]` as the lowest byte.
- Accepting the first message of a frame (no frame open):
  - `acc` = {V, `C[15:8]`, `C[7:0]`}, where `C = (in_count == 0) ? 1 : in_count`.
  - `acc_cnt = 4 + L`.
  - `msg_rem = C - 1`. The frame is now open.
- Accepting a later message:
  - `acc |= V << 8*acc_cnt`.
  - `acc_cnt += 2 + L`.
  - `msg_rem -= 1`.
- Frame finishing: set when an accept leaves `msg_rem == 0`.
- EMIT output rules:
  - `m_tvalid = (acc_cnt >= 8) || (finishing && acc_cnt > 0)`.
  - `m_tdata` = `acc` bytes 0..7. Bytes at index ≥ `acc_cnt` are driven 0.
  - `m_tkeep = 8'hFF` when `acc_cnt >= 8`, else `(1 << acc_cnt) - 1`.
  - `m_tlast = finishing && acc_cnt <= 8`.
- On transfer (`m_tvalid && m_tready`):
  - `acc` shifts right 64 bits.
  - `acc_cnt -= min(8, acc_cnt)`.
  - If `m_tlast` was set, the frame closes, `acc_cnt` becomes 0 and the finishing flag clears.
- `in_error` is registered: it pulses in the cycle after an accept where `in_length > MAX_MSG_BYTES` or (first message and `in_count == 0`).

## Timing
- Reset values (all asynchronous):
  - `m_tvalid`, `m_tlast`, `in_error`, `in_ready` = 0.
  - `m_tdata` = 0, `m_tkeep` = 0.
  - `acc_cnt` = 0, `msg_rem` = 0, frame closed, state IDLE.
- `in_ready` first rises in the second cycle after `rst_n` deasserts.
- Latency: an accept at edge N gives `m_tvalid` = 1 from cycle N+1 when a word is available.
- Output stability: while `m_tvalid && !m_tready`, `m_tdata`, `m_tkeep` and `m_tlast` hold stable; `m_tvalid` never drops without a transfer.
- Throughput: one message per (words emitted + 1) cycles at `m_tready = 1`. No bubbles inside a message's words.
- Exact multiple of 8: if the final word lands exactly on a word boundary (`acc_cnt == 8` while finishing), it goes out with `m_tkeep = FF` and `m_tlast = 1`. No empty word follows.
- Reset mid-frame: everything is discarded and no further words are emitted. The next accepted message starts a new frame with a count header.
- `in_count` on non-first messages is ignored.

## Test plan
- Single short message:
  - Stimulus: count=1, len=4, data A1 A2 A3 A4.
  - Required: one word `0xA4A3A2A1_0004_0001`, `tkeep` FF, `tlast` 1.
- Two messages:
  - Stimulus: count=2, lens 3 (B1..B3) and 5 (C1..C5).
  - Required: word0 `0x05B3B2B1_0003_0002`, `tkeep` FF, `tlast` 0; word1 `0x0000C5C4C3C2C1_00`, `tkeep` 3F, `tlast` 1.
- Maximum length:
  - Stimulus: count=1, len=32 (bytes 00..1F).
  - Required: 5 words; word4 `tkeep` 0F, `tlast` 1; word0 bytes 01 00 20 00 00 01 02 03.
- Backpressure:
  - Stimulus: `m_tready` held low 3 cycles during word1 of the two-message case.
  - Required: `m_tdata`, `m_tkeep`, `m_tlast` stable, `in_ready` 0, identical output words.
- Clamp and count errors:
  - len=40 gives length field 32 (0x0020) and one `in_error` pulse.
  - count=0 gives header 0x0001, a single-message frame and one `in_error` pulse.
- Reset and loopback:
  - Stimulus: `rst_n` pulsed low during word1 of a frame.
  - Required: all outputs 0 immediately; the next frame begins with its count header.
  - Loopback: feeding 20 random frames into `msg_parser` reproduces every length and payload.
